// File: rtl/bit_serial_alu_seq_if.sv
// Request/response bundle of the bit-serial ALU sequencer.
//   master : requester side (drives start/operands/controls, observes status/result)
//   slave  : sequencer side (samples the request, drives busy/done/result/cout/ovf)
// Signals:
//   start, a_in, b_in, mode_in, opcode_in, cin_init, chain_en : request
//   busy, done, result, cout, ovf                             : status/result
interface bit_serial_alu_seq_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [1:0]       mode_in;
  logic             opcode_in;
  logic             cin_init;
  logic             chain_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a_in, b_in, mode_in, opcode_in, cin_init, chain_en,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, a_in, b_in, mode_in, opcode_in, cin_init, chain_en,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer around an external combinational 1-bit ALU slice.
// Latches WIDTH-bit operands on start, streams them LSB-first through the slice
// one bit per clock (optionally chaining slice cout into the next cin), and
// reassembles the result word plus final carry-out and signed overflow.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : start/operands/controls in; busy/done/result/cout/ovf out
//   slice_mode, slice_opcode, slice_ain, slice_bin, slice_cin : to the slice
//   slice_result, slice_cout                                  : from the slice
module bit_serial_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  bit_serial_alu_seq_if.slave         bus,
  output logic [1:0]                  slice_mode,
  output logic                        slice_opcode,
  output logic                        slice_ain,
  output logic                        slice_bin,
  output logic                        slice_cin,
  input  logic                        slice_result,
  input  logic                        slice_cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [1:0]        mode_q, mode_d;
  logic              opcode_q, opcode_d;
  logic              cin_init_q, cin_init_d;
  logic              chain_en_q, chain_en_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    result_d     = result_q;
    mode_d       = mode_q;
    opcode_d     = opcode_q;
    cin_init_d   = cin_init_q;
    chain_en_d   = chain_en_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
    slice_mode   = 2'b00;
    slice_opcode = 1'b0;
    slice_ain    = 1'b0;
    slice_bin    = 1'b0;
    slice_cin    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sh_d     = bus.a_in;
          b_sh_d     = bus.b_in;
          mode_d     = bus.mode_in;
          opcode_d   = bus.opcode_in;
          cin_init_d = bus.cin_init;
          chain_en_d = bus.chain_en;
          carry_d    = bus.cin_init;
          cnt_d      = '0;
          result_d   = '0;
          state_d    = StRun;
        end
      end
      StRun: begin
        slice_mode   = mode_q;
        slice_opcode = opcode_q;
        slice_ain    = a_sh_q[0];
        slice_bin    = b_sh_q[0];
        slice_cin    = carry_q;
        // Result fills from the MSB end so bit 0 lands at index 0 after WIDTH shifts.
        result_d     = {slice_result, result_q[WIDTH-1:1]};
        a_sh_d       = a_sh_q >> 1;
        b_sh_d       = b_sh_q >> 1;
        carry_d      = chain_en_q ? slice_cout : cin_init_q;
        cnt_d        = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          cout_d  = slice_cout;
          // Carry into MSB differs from carry out of MSB -> signed overflow.
          ovf_d   = carry_q ^ slice_cout;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      result_q   <= '0;
      mode_q     <= 2'b00;
      opcode_q   <= 1'b0;
      cin_init_q <= 1'b0;
      chain_en_q <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      result_q   <= result_d;
      mode_q     <= mode_d;
      opcode_q   <= opcode_d;
      cin_init_q <= cin_init_d;
      chain_en_q <= chain_en_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule
